stimulus_gen: RTL and testbench
===============================

STIMULUS_GEN -- requirements
Module: stimulus_gen

Interface
REQ-001 Parameter N, default 16: number of vector lanes (>=1).
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane (>=8).
REQ-003 Parameter FRAME_LEN, default 8: accepted beats per frame (>=1).
REQ-004 Parameter FRAMES_PER_CHAIN, default 4: frames per chain (>=1).
REQ-005 Parameter VALID_GAP, default 0: idle cycles inserted after each accepted beat (>=0).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  start/stop request for beat generation.
REQ-009 mode  input  2  data mode: 0 HOLD, 1 INC, 2 LFSR, 3 RAMP.
REQ-010 seed  input  DATA_WIDTH  initial lane value base.
REQ-011 ready  input  1  downstream acceptance; a beat transfers when valid && ready.
REQ-012 vector_out  output  N*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 valid  output  1  vector_out/eof hold a beat.
REQ-014 eof  output  2  bit0 last beat of frame; bit1 last beat of chain.
REQ-015 beat_count  output  32  number of accepted beats, wraps at 2^32.

Function
REQ-016 FSM states SHALL be IDLE, SEND, GAP; valid SHALL be 1 only in SEND.
REQ-017 IDLE -> SEND when enable=1; on this transition lane k SHALL load seed+k (mod 2^DATA_WIDTH), frame and chain indices unchanged.
REQ-018 In SEND, while ready=0 the outputs vector_out, eof, valid SHALL be held stable regardless of enable or mode (no beat retraction).
REQ-019 On acceptance, next state SHALL be IDLE if enable=0, else GAP if VALID_GAP>0, else SEND (back-to-back beats, one per cycle).
REQ-020 GAP SHALL last exactly VALID_GAP cycles, then go to SEND if enable=1, else IDLE.
REQ-021 On acceptance, every lane SHALL advance per mode sampled that cycle: HOLD unchanged; INC lane k += k+1; LFSR xorshift x^=x<<13, x^=x>>17, x^=x<<5 truncated to DATA_WIDTH, a zero lane first replaced by 1; RAMP lane k += 1; all arithmetic modulo 2^DATA_WIDTH.
REQ-022 Frame index SHALL count accepted beats 0..FRAME_LEN-1 and wrap; chain index SHALL increment when frame index wraps, counting 0..FRAMES_PER_CHAIN-1 and wrapping.
REQ-023 eof[0] SHALL equal (frame index == FRAME_LEN-1) and eof[1] SHALL equal eof[0] && (chain index == FRAMES_PER_CHAIN-1), both for the beat currently presented; eof SHALL be 0 when valid=0.
REQ-024 beat_count SHALL increment by 1 on each accepted beat, wrapping 0xFFFFFFFF -> 0.
REQ-025 Re-entry to SEND from IDLE SHALL reload lanes from seed but SHALL NOT reset frame/chain indices or beat_count.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, valid=0, eof=0, vector_out=0, beat_count=0, frame and chain indices 0, regardless of clk.
REQ-027 Reset asserted mid-beat or mid-GAP SHALL discard that beat; first cycle after release SHALL be IDLE.

Configuration
REQ-028 Macro STIMULUS_GEN_LFSR_EN defined: LFSR mode per REQ-021 compiled in.
REQ-029 Macro STIMULUS_GEN_LFSR_EN undefined: no xorshift logic synthesised; mode 2 SHALL behave exactly as INC.

Verification
REQ-030 N=4, DW=32, seed=0x100, mode=1, enable=1, ready=1 -> beats lane0..3: {100,101,102,103}, {101,103,105,107}, {102,105,108,10B} hex, one per cycle.
REQ-031 FRAME_LEN=2, FRAMES_PER_CHAIN=2, ready=1 -> eof sequence 00,01,00,11,00,01 over six beats; beat_count=6.
REQ-032 ready=0 for 5 cycles mid-stream, enable toggled and mode changed meanwhile -> vector_out/eof/valid constant for all 5 cycles; beat accepted on ready=1.
REQ-033 VALID_GAP=2, ready=1 -> valid pattern 1,0,0,1,0,0; beat_count increments only on valid cycles.
REQ-034 mode=2, lane value 0, LFSR_EN defined -> next lane 0x00042021 (DW=32); LFSR_EN undefined -> lane k increments by k+1.
REQ-035 reset_n pulsed low mid-SEND between clk edges -> valid, eof, vector_out, beat_count read 0 before next edge; FSM resumes from IDLE.

Source files
------------

// File: rtl/stimulus_gen.sv
// rtl/stimulus_gen.sv - multi-lane beat generator with frame/chain end markers and ready/valid handshake
// Define STIMULUS_GEN_LFSR_EN to build xorshift mode 2; otherwise mode 2 falls back to INC.
module stimulus_gen #(
  parameter int N                = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int FRAME_LEN        = 8,
  parameter int FRAMES_PER_CHAIN = 4,
  parameter int VALID_GAP        = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     seed,
  input  logic                      ready,
  output logic [N*DATA_WIDTH-1:0]   vector_out,
  output logic                      valid,
  output logic [1:0]                eof,
  output logic [31:0]               beat_count
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW = (FRAMES_PER_CHAIN > 1) ? $clog2(FRAMES_PER_CHAIN) : 1;
  localparam int GW = (VALID_GAP > 1) ? $clog2(VALID_GAP) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CHAIN_LAST = CW'(FRAMES_PER_CHAIN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((VALID_GAP > 0) ? VALID_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] lane [N];
  logic [FW-1:0]         frame_idx;
  logic [CW-1:0]         chain_idx;
  logic [GW-1:0]         gap_cnt;
  logic [FW-1:0]         frame_nxt;
  logic [CW-1:0]         chain_nxt;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign vector_out[g*DATA_WIDTH +: DATA_WIDTH] = lane[g];
  end

  always_comb begin
    frame_nxt = frame_idx + FW'(1);
    chain_nxt = chain_idx;
    if (frame_idx == FRAME_LAST) begin
      frame_nxt = '0;
      chain_nxt = (chain_idx == CHAIN_LAST) ? '0 : chain_idx + CW'(1);
    end
  end

  function automatic logic [1:0] eof_of(input logic [FW-1:0] f, input logic [CW-1:0] c);
    logic last_f;
    last_f = (f == FRAME_LAST);
    return {last_f && (c == CHAIN_LAST), last_f};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] x,
                                                    input int k, input logic [1:0] m);
    logic [DATA_WIDTH-1:0] y;
    y = x;
    case (m)
      2'd0: y = x;
      2'd1: y = x + DATA_WIDTH'(k + 1);
`ifdef STIMULUS_GEN_LFSR_EN
      2'd2: begin
        // xorshift has a stuck-at-zero fixed point, so a zero lane is kicked to 1 first
        y = (x == '0) ? DATA_WIDTH'(1) : x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
      end
`else
      2'd2: y = x + DATA_WIDTH'(k + 1);
`endif
      default: y = x + DATA_WIDTH'(1);
    endcase
    return y;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= 1'b0;
      eof        <= 2'b00;
      beat_count <= '0;
      frame_idx  <= '0;
      chain_idx  <= '0;
      gap_cnt    <= '0;
      for (int k = 0; k < N; k++) lane[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SEND;
            valid <= 1'b1;
            eof   <= eof_of(frame_idx, chain_idx);
            for (int k = 0; k < N; k++) lane[k] <= seed + DATA_WIDTH'(k);
          end
        end
        SEND: begin
          // outputs only move on acceptance, so a stalled beat is never retracted
          if (ready) begin
            beat_count <= beat_count + 32'd1;
            frame_idx  <= frame_nxt;
            chain_idx  <= chain_nxt;
            for (int k = 0; k < N; k++) lane[k] <= advance(lane[k], k, mode);
            if (!enable) begin
              state <= IDLE;
              valid <= 1'b0;
              eof   <= 2'b00;
            end else if (VALID_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
              valid   <= 1'b0;
              eof     <= 2'b00;
            end else begin
              eof <= eof_of(frame_nxt, chain_nxt);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (enable) begin
              state <= SEND;
              valid <= 1'b1;
              eof   <= eof_of(frame_idx, chain_idx);
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          eof   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stimulus_gen.sv
// tb/tb_stimulus_gen.sv - directed self-checking bench for stimulus_gen
module tb_stimulus_gen;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, enable_b;
  logic [1:0]   mode;
  logic [31:0]  seed;
  logic         ready;
  logic [127:0] vec_a, vec_b;
  logic         valid_a, valid_b;
  logic [1:0]   eof_a, eof_b;
  logic [31:0]  bc_a, bc_b;
  logic         one = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stimulus_gen #(.N(4), .DATA_WIDTH(32), .FRAME_LEN(2), .FRAMES_PER_CHAIN(2), .VALID_GAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .seed(seed), .ready(ready),
    .vector_out(vec_a), .valid(valid_a), .eof(eof_a), .beat_count(bc_a)
  );

  stimulus_gen #(.N(4), .DATA_WIDTH(32), .FRAME_LEN(8), .FRAMES_PER_CHAIN(4), .VALID_GAP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_b), .mode(mode), .seed(seed), .ready(one),
    .vector_out(vec_b), .valid(valid_b), .eof(eof_b), .beat_count(bc_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_a(input int k);
    return vec_a[k*32 +: 32];
  endfunction

  logic [1:0]  eof_seq [6] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01};
  logic        gap_v   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] gap_bc  [6] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};

  initial begin
    reset_n = 1'b1; enable = 1'b0; enable_b = 1'b0; mode = 2'd1; seed = 32'h100; ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_eof", 64'(eof_a), 64'd0);
    check("rst_vec", 64'(vec_a[63:0] | vec_a[127:64]), 64'd0);
    check("rst_bc", 64'(bc_a), 64'd0);
    #9 reset_n = 1'b1;

    // inter-beat gap on the VALID_GAP=2 instance
    enable_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("gap_valid%0d", i), 64'(valid_b), 64'(gap_v[i]));
      check($sformatf("gap_bc%0d", i), 64'(bc_b), 64'(gap_bc[i]));
    end
    enable_b = 1'b0;

    // INC stream with frame/chain markers
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("eof%0d", i), 64'(eof_a), 64'(eof_seq[i]));
      if (i < 3)
        for (int k = 0; k < 4; k++)
          check($sformatf("inc_b%0d_l%0d", i, k), 64'(lane_a(k)), 64'(32'h100 + k + i * (k + 1)));
    end
    step();
    check("bc_six", 64'(bc_a), 64'd6);

    // stall with enable and mode wiggling
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = i[0];
      mode = 2'(i);
      step();
      check($sformatf("stall_valid%0d", i), 64'(valid_a), 64'd1);
      check($sformatf("stall_eof%0d", i), 64'(eof_a), 64'd0);
      check($sformatf("stall_l0_%0d", i), 64'(lane_a(0)), 64'h106);
      check($sformatf("stall_l3_%0d", i), 64'(lane_a(3)), 64'h11B);
      check($sformatf("stall_bc%0d", i), 64'(bc_a), 64'd6);
    end
    ready = 1'b1; enable = 1'b1; mode = 2'd3;
    step();
    check("ramp_bc", 64'(bc_a), 64'd7);
    check("ramp_l0", 64'(lane_a(0)), 64'h107);
    check("ramp_l3", 64'(lane_a(3)), 64'h11C);
    check("ramp_eof", 64'(eof_a), 64'b11);

    // drop to IDLE, then re-enter with a new seed
    enable = 1'b0;
    step();
    check("idle_valid", 64'(valid_a), 64'd0);
    check("idle_eof", 64'(eof_a), 64'd0);
    check("idle_bc", 64'(bc_a), 64'd8);
    enable = 1'b1; seed = 32'h200; mode = 2'd1;
    step();
    check("reent_l0", 64'(lane_a(0)), 64'h200);
    check("reent_l3", 64'(lane_a(3)), 64'h203);
    check("reent_eof", 64'(eof_a), 64'd0);
    check("reent_bc", 64'(bc_a), 64'd8);
    step();
    check("reent_bc2", 64'(bc_a), 64'd9);
    check("reent_eof2", 64'(eof_a), 64'b01);

    // asynchronous reset between edges
    #1 reset_n = 1'b0;
    #1;
    check("areset_valid", 64'(valid_a), 64'd0);
    check("areset_eof", 64'(eof_a), 64'd0);
    check("areset_vec", 64'(vec_a[63:0] | vec_a[127:64]), 64'd0);
    check("areset_bc", 64'(bc_a), 64'd0);
    reset_n = 1'b1;
    step();
    check("resume_valid", 64'(valid_a), 64'd1);
    check("resume_l0", 64'(lane_a(0)), 64'h200);
    check("resume_bc", 64'(bc_a), 64'd0);

    // mode 2 from a zero lane
    enable = 1'b0;
    step();
    enable = 1'b1; seed = 32'h0; mode = 2'd2;
    step();
    check("m2_start_l0", 64'(lane_a(0)), 64'd0);
    step();
`ifdef STIMULUS_GEN_LFSR_EN
    check("m2_l0", 64'(lane_a(0)), 64'h42021);
    check("m2_l1", 64'(lane_a(1)), 64'h42021);
`else
    check("m2_l0", 64'(lane_a(0)), 64'h1);
    check("m2_l1", 64'(lane_a(1)), 64'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
